// File: rtl/matrix_key_scan.sv
`timescale 1ns/1ps
// 4x4 active-low keypad scanner: drives one row low per slot, samples the
// synchronised columns at the end of each slot and debounces every key independently.
module matrix_key_scan #(
    parameter int SCAN_DIV  = 6000,
    parameter int DEB_SCANS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [15:0] key_out,
    output logic        key_any,
    output logic [3:0]  key_code,
    output logic        key_evt
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
    // deb + 1 == DEB_SCANS is the same test as deb == DEB_SCANS - 1, without overflow
    localparam logic [3:0]  DEB_LAST = 4'(DEB_SCANS - 1);

    typedef enum logic [1:0] {
        ROW0 = 2'd0,
        ROW1 = 2'd1,
        ROW2 = 2'd2,
        ROW3 = 2'd3
    } row_state_t;

    logic [3:0]  col_meta_reg;
    logic [3:0]  col_sync_reg;
    logic [3:0]  col_s;
    logic [15:0] div_cnt_reg;
    logic        tick;
    row_state_t  state_reg;
    logic [3:0]  row_reg;
    logic [15:0] key_out_reg;
    logic [15:0] key_next;
    logic        key_any_reg;
    logic [3:0]  key_code_reg;
    logic [3:0]  key_code_next;
    logic        key_evt_reg;

    // Released lines read as 1 through the pull-ups, so the synchroniser resets high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_reg <= 4'hF;
            col_sync_reg <= 4'hF;
        end else begin
            col_meta_reg <= col;
            col_sync_reg <= col_meta_reg;
        end
    end

    assign col_s = ~col_sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_reg <= '0;
        end else if (tick) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + 16'd1;
        end
    end

    assign tick = (div_cnt_reg == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ROW0;
            row_reg   <= 4'b1110;
        end else if (tick) begin
            case (state_reg)
                ROW0: begin
                    state_reg <= ROW1;
                    row_reg   <= 4'b1101;
                end
                ROW1: begin
                    state_reg <= ROW2;
                    row_reg   <= 4'b1011;
                end
                ROW2: begin
                    state_reg <= ROW3;
                    row_reg   <= 4'b0111;
                end
                default: begin
                    state_reg <= ROW0;
                    row_reg   <= 4'b1110;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_key
            localparam logic [1:0] ROW_IDX = 2'(gi / 4);
            localparam int         COL_IDX = gi % 4;

            logic [3:0] deb_reg;
            logic       sample;
            logic       raw;
            logic       disagree;
            logic       qualify;

            assign sample   = tick && (state_reg == row_state_t'(ROW_IDX));
            assign raw      = col_s[COL_IDX];
            assign disagree = (raw != key_out_reg[gi]);
            assign qualify  = sample && disagree && (deb_reg == DEB_LAST);

            // Any agreeing sample restarts the count, so bounce never accumulates.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    deb_reg <= '0;
                end else if (sample) begin
                    if (!disagree || deb_reg == DEB_LAST) begin
                        deb_reg <= '0;
                    end else begin
                        deb_reg <= deb_reg + 4'd1;
                    end
                end
            end

            assign key_next[gi] = qualify ? raw : key_out_reg[gi];
        end
    endgenerate

    always_comb begin
        key_code_next = '0;
        for (int i = 15; i >= 0; i--) begin
            if (key_next[i]) begin
                key_code_next = 4'(i);
            end
        end
    end

    // All four outputs load from key_next on one edge so they never disagree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_out_reg  <= '0;
            key_any_reg  <= 1'b0;
            key_code_reg <= '0;
            key_evt_reg  <= 1'b0;
        end else begin
            key_out_reg  <= key_next;
            key_any_reg  <= |key_next;
            key_code_reg <= key_code_next;
            key_evt_reg  <= (key_next != key_out_reg);
        end
    end

    assign row      = row_reg;
    assign key_out  = key_out_reg;
    assign key_any  = key_any_reg;
    assign key_code = key_code_reg;
    assign key_evt  = key_evt_reg;

endmodule

// File: tb/tb_matrix_key_scan.sv
`timescale 1ns/1ps
// Directed bench for matrix_key_scan: a behavioural keypad closes row/column
// contacts, and hand-computed timings/values are checked with immediate assertions.
module tb_matrix_key_scan;

    localparam int SCAN_DIV  = 8;
    localparam int DEB_SCANS = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] key_out;
    logic        key_any;
    logic [3:0]  key_code;
    logic        key_evt;

    logic [15:0] pressed = '0;
    logic        force_low = 1'b1;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          evt_cnt = 0;
    int          base;
    int          cyc;

    always #5 clk = ~clk;

    // Keypad: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        col = 4'hF;
        if (force_low) begin
            col = 4'h0;
        end else begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
                end
            end
        end
    end

    matrix_key_scan #(
        .SCAN_DIV (SCAN_DIV),
        .DEB_SCANS(DEB_SCANS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .col     (col),
        .row     (row),
        .key_out (key_out),
        .key_any (key_any),
        .key_code(key_code),
        .key_evt (key_evt)
    );

    always @(negedge clk) begin
        if (rst_n && key_evt) begin
            evt_cnt++;
            $display("evt  t=%0t key_out=%04h key_any=%0b key_code=%0d", $time, key_out, key_any, key_code);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; counts clock edges until key_out reaches exp.
    task automatic wait_key(input logic [15:0] exp, input int budget, output int cycles);
        cycles = 0;
        while (key_out !== exp && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        // Reset with every column pulled low
        rst_n = 1'b0;
        force_low = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_row", 32'(row), 32'h0000000E);
        check("reset_key_out", 32'(key_out), 32'h0);
        check("reset_key_evt", 32'(key_evt), 32'h0);
        check("reset_key_any", 32'(key_any), 32'h0);
        check("reset_key_code", 32'(key_code), 32'h0);
        force_low = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Row stepping every SCAN_DIV clocks
        repeat (7) @(negedge clk);
        check("row_hold_slot0", 32'(row), 32'h0000000E);
        @(negedge clk);
        check("row_step1", 32'(row), 32'h0000000D);
        repeat (8) @(negedge clk);
        check("row_step2", 32'(row), 32'h0000000B);
        repeat (8) @(negedge clk);
        check("row_step3", 32'(row), 32'h00000007);
        repeat (8) @(negedge clk);
        check("row_step0", 32'(row), 32'h0000000E);
        $display("step reset/row sequence done");

        // Single press of key 6
        base = evt_cnt;
        pressed = 16'h0040;
        wait_key(16'h0040, 120, cyc);
        $display("step press key6 latency=%0d", cyc);
        check("press_key_out", 32'(key_out), 32'h00000040);
        check("press_lat_min", 32'(cyc >= 67), 32'd1);
        check("press_lat_max", 32'(cyc <= 99), 32'd1);
        check("press_evt", 32'(key_evt), 32'd1);
        check("press_key_any", 32'(key_any), 32'd1);
        check("press_key_code", 32'(key_code), 32'd6);
        @(negedge clk);
        check("press_evt_width", 32'(key_evt), 32'd0);
        repeat (4) @(negedge clk);
        check("press_evt_count", 32'(evt_cnt - base), 32'd1);

        // Release of key 6
        base = evt_cnt;
        pressed = 16'h0000;
        wait_key(16'h0000, 120, cyc);
        $display("step release key6 latency=%0d", cyc);
        check("release_key_out", 32'(key_out), 32'h0);
        check("release_lat_min", 32'(cyc >= 67), 32'd1);
        check("release_lat_max", 32'(cyc <= 99), 32'd1);
        check("release_evt", 32'(key_evt), 32'd1);
        check("release_key_any", 32'(key_any), 32'd0);
        repeat (4) @(negedge clk);
        check("release_evt_count", 32'(evt_cnt - base), 32'd1);

        // Bounce on key 0, phase-locked to the start of the ROW0 slot
        for (int i = 0; i < 40 && row == 4'b1110; i++) @(negedge clk);
        for (int i = 0; i < 40 && row != 4'b1110; i++) @(negedge clk);
        check("bounce_sync", 32'(row), 32'h0000000E);
        base = evt_cnt;
        pressed[0] = 1'b1;
        for (int k = 1; k <= 296; k++) begin
            @(negedge clk);
            pressed[0] = (k >= 200) || (((k / 20) % 2) == 0);
            if (k == 200) check("bounce_during", 32'(key_out), 32'h0);
            if (k == 295) begin
                check("bounce_before_flip", 32'(key_out), 32'h0);
                check("bounce_no_evt_yet", 32'(evt_cnt - base), 32'd0);
            end
            if (k == 296) begin
                check("bounce_key_out", 32'(key_out), 32'h00000001);
                check("bounce_evt", 32'(key_evt), 32'd1);
                check("bounce_key_any", 32'(key_any), 32'd1);
                check("bounce_key_code", 32'(key_code), 32'd0);
            end
        end
        repeat (4) @(negedge clk);
        check("bounce_evt_count", 32'(evt_cnt - base), 32'd1);
        $display("step bounce key0 done");

        pressed = 16'h0000;
        wait_key(16'h0000, 120, cyc);
        check("bounce_release", 32'(key_out), 32'h0);
        repeat (4) @(negedge clk);

        // Keys 5 and 15 together (different rows)
        base = evt_cnt;
        pressed = 16'h8020;
        wait_key(16'h8020, 140, cyc);
        $display("step multi press 5+15 latency=%0d", cyc);
        check("multi_key_out", 32'(key_out), 32'h00008020);
        check("multi_key_code", 32'(key_code), 32'd5);
        check("multi_key_any", 32'(key_any), 32'd1);
        repeat (4) @(negedge clk);
        check("multi_evt_count", 32'(evt_cnt - base), 32'd2);

        base = evt_cnt;
        pressed = 16'h0000;
        wait_key(16'h0000, 140, cyc);
        check("multi_release", 32'(key_out), 32'h0);
        repeat (4) @(negedge clk);
        check("multi_release_evts", 32'(evt_cnt - base), 32'd2);

        // Reset while key 6 is held
        pressed = 16'h0040;
        wait_key(16'h0040, 120, cyc);
        check("midrst_pre", 32'(key_out), 32'h00000040);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_key_out", 32'(key_out), 32'h0);
        check("midrst_key_any", 32'(key_any), 32'h0);
        check("midrst_key_code", 32'(key_code), 32'h0);
        check("midrst_key_evt", 32'(key_evt), 32'h0);
        check("midrst_row", 32'(row), 32'h0000000E);
        @(negedge clk);
        rst_n = 1'b1;
        wait_key(16'h0040, 120, cyc);
        $display("step requalify key6 latency=%0d", cyc);
        check("midrst_requal", 32'(key_out), 32'h00000040);
        check("midrst_lat_min", 32'(cyc >= 64), 32'd1);
        check("midrst_lat_max", 32'(cyc <= 99), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
